// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory server.
package imem_pkg;

  // Word returned whenever the core must not see real program contents
  // (addi x0, x0, 0).
  localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RESET_S = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2
  } state_e;

  // Builds the word to commit when a byte lands in `lane`: lanes below
  // come from the pack register, lanes above are zero so a short final
  // word is padded with 0x00.
  function automatic logic [31:0] pack_word(input logic [23:0] lanes,
                                            input logic [1:0]  lane,
                                            input logic [7:0]  data);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < lane) w[i*8 +: 8] = lanes[i*8 +: 8];
    end
    w[{lane, 3'b000} +: 8] = data;
    return w;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Word RAM: one synchronous write port, one asynchronous read port.
module imem_ram #(
  parameter int DEPTH_WORDS = 1024,
  localparam int ADDR_W = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];

  // Write port: one word per edge when enabled.
  // NOTE: the array has no reset -- contents survive reset and are simply
  // overwritten by the next load; resetting it would forbid RAM inference.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/instr_mem_server.sv
// Instruction-memory responder: byte-stream loader that fills the RAM while
// holding the core in reset, then a zero-latency fetch port.
module instr_mem_server
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int ADDR_W = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_addr,
  output logic [31:0]       instr_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  input  logic              reload,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_overflow
);

  state_e          state_q;
  logic [1:0]      byte_cnt_q;
  logic [23:0]     pack_q;
  logic [ADDR_W:0] word_count_q;
  logic            err_q;
  logic            ld_ready_q;
  logic            cpu_hold_q;
  logic            load_done_q;

  logic            accept;
  logic            full;
  logic            commit;
  logic [31:0]     wr_word;
  logic [31:0]     rd_word;
  logic            addr_in_range;
  logic            addr_lsb_unused;

  // ld_ready_q is only ever high in LOAD, so it alone qualifies a handshake.
  assign accept  = ld_valid & ld_ready_q;
  assign full    = (word_count_q == (ADDR_W+1)'(DEPTH_WORDS));
  assign commit  = accept & ~full & ((byte_cnt_q == 2'd3) | ld_last);
  assign wr_word = pack_word(pack_q, byte_cnt_q, ld_data);

  imem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk     (clk),
    .we_i    (commit),
    .waddr_i (word_count_q[ADDR_W-1:0]),
    .wdata_i (wr_word),
    .raddr_i (instr_addr[ADDR_W+1:2]),
    .rdata_o (rd_word)
  );

  // Load FSM, byte packer and registered handshake/hold outputs.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= RESET_S;
      byte_cnt_q   <= 2'd0;
      pack_q       <= '0;
      word_count_q <= '0;
      err_q        <= 1'b0;
      ld_ready_q   <= 1'b0;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
    end else begin
      case (state_q)
        RESET_S: begin
          state_q    <= LOAD;
          ld_ready_q <= 1'b1;
        end
        LOAD: begin
          if (accept) begin
            if (full) begin
              // RAM already full: drop the byte, remember it happened.
              err_q <= 1'b1;
            end else begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
              if (commit) begin
                word_count_q <= word_count_q + (ADDR_W+1)'(1);
                pack_q       <= '0;
              end else begin
                pack_q <= wr_word[23:0];
              end
            end
            if (ld_last) begin
              state_q     <= RUN;
              byte_cnt_q  <= 2'd0;
              ld_ready_q  <= 1'b0;
              cpu_hold_q  <= 1'b0;
              load_done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (reload) begin
            state_q      <= LOAD;
            word_count_q <= '0;
            byte_cnt_q   <= 2'd0;
            pack_q       <= '0;
            err_q        <= 1'b0;
            ld_ready_q   <= 1'b1;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= RESET_S;
          ld_ready_q  <= 1'b0;
          cpu_hold_q  <= 1'b1;
          load_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Fetch mux: real words only in RUN and only for addresses inside the RAM.
  assign addr_in_range   = (instr_addr[31:ADDR_W+2] == '0);
  assign instr_data      = ((state_q == RUN) && addr_in_range) ? rd_word : IMEM_NOP;
  assign addr_lsb_unused = ^instr_addr[1:0];

  assign ld_ready     = ld_ready_q;
  assign cpu_hold     = cpu_hold_q;
  assign load_done    = load_done_q;
  assign word_count   = word_count_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_instr_mem_server.sv
// Self-checking bench for instr_mem_server (DEPTH_WORDS = 4).
module tb_instr_mem_server;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int PH_RESET = 0;
  localparam int PH_LOAD  = 1;
  localparam int PH_RUN   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_addr;
  logic [31:0] instr_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        reload;
  logic        cpu_hold;
  logic        load_done;
  logic [2:0]  word_count;
  logic        err_overflow;

  int checks = 0;
  int errors = 0;

  // Behavioural model: load phase, count of bytes stored this load, word image.
  int          m_phase = PH_RESET;
  int          m_n = 0;
  bit          m_err = 1'b0;
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];

  instr_mem_server #(.DEPTH_WORDS(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_addr   (instr_addr),
    .instr_data   (instr_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .reload       (reload),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .word_count   (word_count),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: applies the loader rules to the inputs present at each edge.
  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_phase = PH_RESET;
        m_n     = 0;
        m_err   = 1'b0;
      end else begin
        case (m_phase)
          PH_RESET: m_phase = PH_LOAD;
          PH_LOAD: begin
            if (ld_valid) begin
              if (m_n >= 4 * DEPTH) begin
                m_err = 1'b1;
              end else begin
                int w;
                int lane;
                w    = m_n / 4;
                lane = m_n % 4;
                m_mem[w][lane*8 +: 8] = ld_data;
                if (ld_last)
                  for (int l = lane + 1; l < 4; l++) m_mem[w][l*8 +: 8] = 8'h00;
                if (lane == 3 || ld_last) m_known[w] = 1'b1;
                m_n++;
              end
              if (ld_last) m_phase = PH_RUN;
            end
          end
          default: begin
            if (reload) begin
              m_phase = PH_LOAD;
              m_n     = 0;
              m_err   = 1'b0;
            end
          end
        endcase
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  initial begin
    forever begin
      int exp_wc;
      int idx;
      @(negedge clk);
      exp_wc = (m_phase == PH_RUN) ? (m_n + 3) / 4 : m_n / 4;
      check("ld_ready",     32'(ld_ready),     32'(m_phase == PH_LOAD));
      check("cpu_hold",     32'(cpu_hold),     32'(m_phase != PH_RUN));
      check("load_done",    32'(load_done),    32'(m_phase == PH_RUN));
      check("word_count",   32'(word_count),   32'(exp_wc));
      check("err_overflow", 32'(err_overflow), 32'(m_err));
      if (m_phase == PH_RUN && instr_addr < 32'(4 * DEPTH)) begin
        idx = int'(instr_addr) / 4;
        if (m_known[idx]) check("instr_data", instr_data, m_mem[idx]);
      end else begin
        check("instr_data_nop", instr_data, NOP);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, errors %0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    ld_valid   = 1'b1;
    ld_data    = b;
    ld_last    = last;
    instr_addr = 32'($urandom_range(0, 31));
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic pulse_reload_from_run();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check("reload_hold",  32'(cpu_hold),     32'd1);
    check("reload_done",  32'(load_done),    32'd0);
    check("reload_wc",    32'(word_count),   32'd0);
    check("reload_err",   32'(err_overflow), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      instr_addr = 32'(4 * i + (i % 4));
      tick();
    end
  endtask

  task automatic read_word(input string name, input logic [31:0] addr, input logic [31:0] exp);
    instr_addr = addr;
    #1;
    check(name, instr_data, exp);
  endtask

  initial begin
    logic [7:0] img1 [8];
    img1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    rst        = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = 8'h00;
    ld_last    = 1'b0;
    reload     = 1'b0;
    instr_addr = 32'h0;
    repeat (3) tick();
    check("rst_ready", 32'(ld_ready),     32'd0);
    check("rst_hold",  32'(cpu_hold),     32'd1);
    check("rst_done",  32'(load_done),    32'd0);
    check("rst_wc",    32'(word_count),   32'd0);
    check("rst_err",   32'(err_overflow), 32'd0);
    rst = 1'b1;
    tick();
    check("load_ready", 32'(ld_ready), 32'd1);

    // Two-word image
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("hold_before_last", 32'(cpu_hold), 32'd1);
      send_byte(img1[i], i == 7);
    end
    check("hold_after_last", 32'(cpu_hold),   32'd0);
    check("img1_done",       32'(load_done),  32'd1);
    check("img1_wc",         32'(word_count), 32'd2);
    read_word("img1_w1",     32'h0000_0004, 32'h0010_0093);
    read_word("img1_w0",     32'h0000_0000, 32'h0000_0013);
    read_word("addr_0x6",    32'h0000_0006, 32'h0010_0093);
    read_word("addr_oor",    32'h0000_1000, NOP);
    idle(6);

    // Partial final word
    pulse_reload_from_run();
    read_word("load_nop", 32'h0000_0004, NOP);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h11 + i), i == 5);
    check("part_wc", 32'(word_count), 32'd2);
    read_word("part_w1", 32'h0000_0004, 32'h0000_1615);
    read_word("part_w0", 32'h0000_0000, 32'h1413_1211);
    idle(5);

    // Overflow, with a reload pulse during LOAD that must be ignored
    pulse_reload_from_run();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check("reload_in_load_wc",    32'(word_count), 32'd1);
    check("reload_in_load_ready", 32'(ld_ready),   32'd1);
    for (int i = 6; i <= 20; i++) begin
      send_byte(8'(i), i == 20);
      if (i == 16) begin
        check("full_wc",  32'(word_count),   32'd4);
        check("full_err", 32'(err_overflow), 32'd0);
      end
    end
    check("ovf_err",  32'(err_overflow), 32'd1);
    check("ovf_wc",   32'(word_count),   32'd4);
    check("ovf_done", 32'(load_done),    32'd1);
    read_word("ovf_w3", 32'h0000_000C, 32'h100F_0E0D);
    read_word("ovf_w0", 32'h0000_0000, 32'h0403_0201);
    idle(5);

    // Reload with a simultaneous byte: that byte is not taken
    reload   = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 8'h55;
    tick();
    reload   = 1'b0;
    ld_valid = 1'b0;
    check("rv_err",   32'(err_overflow), 32'd0);
    check("rv_wc",    32'(word_count),   32'd0);
    check("rv_ready", 32'(ld_ready),     32'd1);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h21 + i), i == 3);
    check("rv_wc1", 32'(word_count), 32'd1);
    read_word("rv_w0", 32'h0000_0000, 32'h2423_2221);
    idle(4);

    // Reset in the middle of a load
    pulse_reload_from_run();
    for (int i = 0; i < 3; i++) send_byte(8'(8'h31 + i), 1'b0);
    rst = 1'b0;
    tick();
    check("midrst_ready", 32'(ld_ready), 32'd0);
    check("midrst_hold",  32'(cpu_hold), 32'd1);
    rst = 1'b1;
    tick();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b1);
    check("midrst_wc",   32'(word_count), 32'd1);
    check("midrst_done", 32'(load_done),  32'd1);
    read_word("midrst_w0", 32'h0000_0000, 32'hDDCC_BBAA);
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_server.md
# instr_mem_server

Instruction-memory responder for the 5-stage `pipeline` core. It serves the core's fetch port (`instr_addr` in, `instr_data` out) from an internal word RAM. It also owns a byte-stream program loader that fills the RAM after reset or on request, holding the core in reset until loading completes.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two, ≥ 4.
- `ADDR_W`, log2(DEPTH_WORDS): word-index width (derived; not overridden).

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `instr_addr`  in  32: byte fetch address from the core.
- `instr_data`  out  32: fetched instruction word (combinational).
- `ld_valid`  in  1: loader byte valid.
- `ld_ready`  out  1: loader byte accepted when `ld_valid & ld_ready`.
- `ld_data`  in  8: loader byte, little-endian within each word.
- `ld_last`  in  1: marks the final byte of the image; qualified by a handshake.
- `reload`  in  1: single-cycle request to re-enter loading.
- `cpu_hold`  out  1: drives the core's reset; 1 = core held.
- `load_done`  out  1: 1 in RUN state.
- `word_count`  out  ADDR_W+1: number of words written in the current load.
- `err_overflow`  out  1: sticky; set when a byte arrives after the RAM is full.

## Operation
- FSM states: `RESET_S` → `LOAD` → `RUN`. `reload` moves RUN → LOAD.
- Reset (`rst`=0): state = RESET_S; `ld_ready`=0, `cpu_hold`=1, `load_done`=0, `word_count`=0, `err_overflow`=0, byte counter=0, pack register=0. RAM contents are not cleared.
- RESET_S moves unconditionally to LOAD on the first edge with `rst`=1.
- LOAD:
  - `ld_ready`=1 and `cpu_hold`=1.
  - Each accepted byte goes into lane `byte_cnt` (lane 0 = bits 7:0), and the 2-bit `byte_cnt` increments.
  - On acceptance of lane 3, the word is written to `mem[word_count]` and `word_count` increments.
- `ld_last` accepted:
  - If the word is partial, unfilled lanes are written as 0x00 and the word is committed on the same edge.
  - The FSM then goes to RUN, and `byte_cnt` is cleared.
- Overflow: while `word_count == DEPTH_WORDS`, accepted bytes are dropped and `err_overflow` is set. `ld_last` still completes the transition to RUN.
- RUN: `ld_ready`=0, `cpu_hold`=0, `load_done`=1. `ld_valid` is ignored.
- `reload` in RUN: go to LOAD; clear `word_count`, `byte_cnt`, the pack register and `err_overflow`. `reload` is ignored in LOAD and RESET_S.
- Fetch path, with index = `instr_addr[ADDR_W+1:2]`:
  - In RUN, `instr_data` = `mem[index]` if `instr_addr[31:ADDR_W+2]` == 0.
  - Otherwise, and in every state other than RUN, `instr_data` = NOP 0x0000_0013.
  - `instr_addr[1:0]` is ignored.

## Timing
- Fetch latency is 0 cycles: `instr_data` is combinational from `instr_addr` and the state.
- A word written on edge N is readable from cycle N+1.
- `cpu_hold` falls in the cycle after the edge that accepts `ld_last`. The core therefore sees its first fetch with a fully written RAM.
- Reset mid-load: the next edge with `rst`=0 discards the partial word and restarts from word 0. Words already written stay in RAM but are reloaded.
- If `ld_last` and `word_count == DEPTH_WORDS` coincide, the byte is dropped, `err_overflow` is set, and the state goes to RUN.
- `reload` and `ld_valid` in the same RUN cycle: go to LOAD; that byte is not accepted, because `ld_ready` was 0.

## Structure
- Shared package `imem_pkg`:
  - `IMEM_NOP` = 32'h0000_0013.
  - State enum {RESET_S, LOAD, RUN}.
- Sub-module `imem_ram`:
  - DEPTH_WORDS×32 array.
  - One synchronous write port (we, waddr, wdata).
  - One asynchronous read port.
- The FSM, byte packer and fetch mux live in the top.

## Test plan
- Reset then 8 bytes 0x13,0x00,0x00,0x00,0x93,0x00,0x10,0x00 with `ld_last` on the 8th:
  - `word_count`=2 and `load_done`=1.
  - `instr_addr`=0x4 → 0x0010_0093; 0x0 → 0x0000_0013.
  - `cpu_hold` falls one cycle after the last handshake.
- Partial word: 6 bytes 0x11..0x16 with `ld_last` on 0x16:
  - word 1 reads 0x0000_1615, and `word_count`=2.
- Overflow with DEPTH_WORDS=4: send 20 bytes.
  - `err_overflow`=1 and `word_count`=4.
  - word 3 holds bytes 13–16.
  - The FSM ends in RUN.
- Addressing in RUN:
  - `instr_addr`=0x0000_1000 (out of range) → 0x0000_0013.
  - `instr_addr`=0x6 → word 1.
  - During LOAD, any address → 0x0000_0013.
- Reset mid-load: assert `rst`=0 after 3 bytes, then load 4 bytes 0xAA,0xBB,0xCC,0xDD with last.
  - word 0 = 0xDDCC_BBAA and `word_count`=1.
- `reload` in RUN:
  - `cpu_hold`=1 and `load_done`=0 next cycle; `word_count` and `err_overflow` cleared.
  - A new 4-byte image overwrites word 0.
  - `reload` pulsed again during LOAD has no effect.
